alu_sequencer: RTL and testbench

Micro-sequencer sitting directly upstream of the combinational `alu` stage. It holds the packed `{A, B}` operand register, drives the ALU's enable, control and operand inputs, and writes the ALU's `{B, C}` output back into its operand register each step. Software loads an 8-entry program of 3-bit ALU opcodes plus initial operands, then pulses `start_i` to run the program back-to-back. Typical uses are Fibonacci-style recurrences and accumulations for the game logic, launched once per VSYNC.

---
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_sequencer
// Description : Micro-sequencer feeding a combinational ALU. Holds the packed
//               {A,B} operand register, steps through an 8-entry opcode
//               program and writes the ALU's {B,C} output back every step.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [2*WIDTH-1:0]   load_ab_i,
    input  logic                 wr_en_i,
    input  logic [2:0]           wr_addr_i,
    input  logic [2:0]           wr_ctl_i,
    input  logic                 start_i,
    input  logic [2:0]           len_i,
    output logic                 en_o,
    output logic [2:0]           ctl_o,
    output logic [2*WIDTH-1:0]   ab_o,
    input  logic [2*WIDTH-1:0]   bc_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH-1:0]     result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_ab;
    logic [2:0]         r_prog [0:7];
    logic [2:0]         r_pc;
    logic [2:0]         r_last;
    logic               w_accept;

    // Loads and program writes are only honoured while not running.
    assign w_accept = (r_state != S_RUN);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: operand register, program counter, latched length.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ab   <= '0;
            r_pc   <= 3'd0;
            r_last <= 3'd0;
        end else begin
            if (r_state == S_RUN) begin
                // ALU result is captured verbatim; no logic on this path.
                r_ab <= bc_i;
                if (r_pc != r_last) begin
                    r_pc <= r_pc + 3'd1;
                end
            end else if (load_i) begin
                r_ab <= load_ab_i;
            end else if ((r_state == S_IDLE) && start_i) begin
                r_last <= len_i;
                r_pc   <= 3'd0;
            end
        end
    end

    // Program memory; frozen during a run so the program cannot change mid-run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                r_prog[i] <= 3'b000;
            end
        end else if (w_accept && wr_en_i) begin
            r_prog[wr_addr_i] <= wr_ctl_i;
        end
    end

    // Next-state and ALU control decode.
    always_comb begin
        w_next = r_state;
        en_o   = 1'b0;
        ctl_o  = 3'b000;
        done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A simultaneous load wins over start.
                if (!load_i && start_i) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                en_o  = 1'b1;
                ctl_o = r_prog[r_pc];
                if (r_pc == r_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign ab_o     = r_ab;
    assign result_o = r_ab[WIDTH-1:0];
    assign busy_o   = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural ALU
//               in the loop and a step-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           load_i = 1'b0;
    logic [2*W-1:0] load_ab_i = '0;
    logic           wr_en_i = 1'b0;
    logic [2:0]     wr_addr_i = '0;
    logic [2:0]     wr_ctl_i = '0;
    logic           start_i = 1'b0;
    logic [2:0]     len_i = '0;
    logic           en_o;
    logic [2:0]     ctl_o;
    logic [2*W-1:0] ab_o;
    logic [2*W-1:0] bc_i;
    logic           busy_o;
    logic           done_o;
    logic [W-1:0]   result_o;

    int tests = 0;
    int fails = 0;

    logic [2:0]     prog_m [0:7];
    logic [2*W-1:0] ab_m;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .load_ab_i(load_ab_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_ctl_i(wr_ctl_i),
        .start_i(start_i), .len_i(len_i), .en_o(en_o), .ctl_o(ctl_o),
        .ab_o(ab_o), .bc_i(bc_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o)
    );

    // ALU semantics: returns {B, C} for operands {A, B}.
    function automatic logic [2*W-1:0] alu_step(input logic [2:0] op, input logic [2*W-1:0] ab);
        int a, b, c;
        a = int'(ab[2*W-1:W]);
        b = int'(ab[W-1:0]);
        case (op)
            3'b000: c = 0;
            3'b001: c = 1;
            3'b010: c = a;
            3'b011: c = b;
            3'b100: c = (a + b) % 256;
            3'b101: c = (a - b + 256) % 256;
            3'b110: c = a & b;
            default: c = a | b;
        endcase
        return {ab[W-1:0], c[W-1:0]};
    endfunction

    // Downstream combinational ALU.
    assign bc_i = alu_step(ctl_o, ab_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2*W-1:0] v);
        load_i = 1'b1;
        load_ab_i = v;
        tick();
        load_i = 1'b0;
        ab_m = v;
        check("load_ab", 32'(ab_o), 32'(ab_m));
    endtask

    task automatic write_prog(input logic [2:0] a, input logic [2:0] op);
        wr_en_i = 1'b1;
        wr_addr_i = a;
        wr_ctl_i = op;
        tick();
        wr_en_i = 1'b0;
        prog_m[a] = op;
    endtask

    // One full run checked step by step against the model.
    task automatic run(input int len, input bit disturb, input bit hold,
                       input bit done_load, input logic [2*W-1:0] dl_val);
        start_i = 1'b1;
        len_i = 3'(len);
        tick();
        if (!hold) start_i = 1'b0;
        for (int k = 0; k <= len; k++) begin
            check($sformatf("run_busy%0d", k), 32'(busy_o), 32'd1);
            check($sformatf("run_en%0d", k), 32'(en_o), 32'd1);
            check($sformatf("run_ctl%0d", k), 32'(ctl_o), 32'(prog_m[k]));
            check($sformatf("run_ab%0d", k), 32'(ab_o), 32'(ab_m));
            check($sformatf("run_nodone%0d", k), 32'(done_o), 32'd0);
            if (disturb && k == 1) begin
                load_i = 1'b1;
                load_ab_i = 16'($urandom);
                start_i = 1'b1;
                wr_en_i = 1'b1;
                wr_addr_i = 3'd2;
                wr_ctl_i = ~prog_m[2];
                len_i = ~3'(len);
            end
            ab_m = alu_step(prog_m[k], ab_m);
            tick();
            if (disturb && k == 1) begin
                load_i = 1'b0;
                wr_en_i = 1'b0;
                start_i = hold;
            end
        end
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_en", 32'(en_o), 32'd0);
        check("done_ctl", 32'(ctl_o), 32'd0);
        check("done_ab", 32'(ab_o), 32'(ab_m));
        check("done_result", 32'(result_o), 32'(ab_m[W-1:0]));
        if (done_load) begin
            load_i = 1'b1;
            load_ab_i = dl_val;
            ab_m = dl_val;
        end
        tick();
        load_i = 1'b0;
        check("idle_done", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_ab", 32'(ab_o), 32'(ab_m));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) prog_m[i] = 3'b000;
        ab_m = '0;

        // Reset values.
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_ctl", 32'(ctl_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ab", 32'(ab_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);

        // Mid-run reset abandons run and clears program.
        for (int i = 0; i < 8; i++) write_prog(3'(i), 3'b111);
        load(16'h0503);
        start_i = 1'b1;
        len_i = 3'd7;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) prog_m[i] = 3'b000;
        ab_m = '0;
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_en", 32'(en_o), 32'd0);
        check("mrst_ab", 32'(ab_o), 32'd0);
        check("mrst_done", 32'(done_o), 32'd0);
        tick();
        check("mrst_done2", 32'(done_o), 32'd0);
        load(16'h1234);
        run(7, 1'b0, 1'b0, 1'b0, '0);

        // Fibonacci.
        for (int i = 0; i < 8; i++) write_prog(3'(i), 3'b100);
        load(16'h0001);
        run(5, 1'b0, 1'b0, 1'b0, '0);
        check("fib_final", 32'(ab_o), 32'h080D);

        // Wrap and subtract.
        load(16'hFF01);
        run(0, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_add", 32'(ab_o), 32'h0100);
        write_prog(3'd0, 3'b101);
        load(16'h0305);
        run(0, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_sub", 32'(ab_o), 32'h05FE);

        // Mixed program.
        write_prog(3'd0, 3'b110);
        write_prog(3'd1, 3'b111);
        write_prog(3'd2, 3'b011);
        write_prog(3'd3, 3'b000);
        write_prog(3'd4, 3'b001);
        load(16'hF03C);
        run(4, 1'b0, 1'b0, 1'b0, '0);
        check("mixed_final", 32'(ab_o), 32'h0001);

        // Inputs ignored during RUN; load accepted in DONE.
        load(16'h2A17);
        run(5, 1'b1, 1'b0, 1'b1, 16'h4455);
        run(7, 1'b0, 1'b0, 1'b0, '0);

        // Simultaneous load and start in IDLE: load wins, no run.
        load_i = 1'b1;
        start_i = 1'b1;
        load_ab_i = 16'h7788;
        tick();
        load_i = 1'b0;
        start_i = 1'b0;
        ab_m = 16'h7788;
        check("ls_busy", 32'(busy_o), 32'd0);
        check("ls_ab", 32'(ab_o), 32'(ab_m));
        tick();
        check("ls_busy2", 32'(busy_o), 32'd0);

        // Back-to-back with start held high.
        run(2, 1'b0, 1'b1, 1'b0, '0);
        run(3, 1'b0, 1'b1, 1'b0, '0);
        run(1, 1'b0, 1'b0, 1'b0, '0);

        // Randomized programs.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 8; i++) write_prog(3'(i), 3'($urandom));
            load(16'($urandom));
            run(int'($urandom_range(0, 7)), 1'($urandom), 1'b0, 1'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
